// File: rtl/dbus_uart.sv
// dbus_uart: memory-mapped 8N1 UART on the CPU data bus.
//   Word map: 0 TXDATA (W), 1 RXDATA (R), 2 STATUS (R/W1C), 3 BAUDDIV (R/W).
// Ports:
//   i_Clk, i_Rst_n            clock, async active-low reset
//   i_Sel, i_DBusAddr         window select and word offset
//   i_DBusRe, i_DBusWe        read / write strobes (write wins if both)
//   i_DBusByteEn, i_DBusWd    write byte enables and data
//   o_DBusRd                  registered read data, valid the cycle after Re
//   i_Rx, o_Tx                serial in (asynchronous) / serial out (idle high)
//   o_Irq                     level interrupt, irq_en & (rx_valid | tx_empty)
module dbus_uart #(
  parameter int unsigned TX_DEPTH     = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Sel,
  input  logic [1:0]  i_DBusAddr,
  input  logic        i_DBusRe,
  input  logic        i_DBusWe,
  input  logic [3:0]  i_DBusByteEn,
  input  logic [31:0] i_DBusWd,
  output logic [31:0] o_DBusRd,
  input  logic        i_Rx,
  output logic        o_Tx,
  output logic        o_Irq
);

  localparam int unsigned PTR_W   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [15:0] BAUD_RST = 16'(CLKS_PER_BIT);
  localparam logic [15:0] BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_e;

  // Bus access qualification
  logic wrAcc, rdAcc, rdRx, statWr, baudWr, txPush;
  assign wrAcc  = i_Sel & i_DBusWe;
  assign rdAcc  = i_Sel & i_DBusRe & ~i_DBusWe;
  assign rdRx   = rdAcc & (i_DBusAddr == 2'd1);
  assign statWr = wrAcc & (i_DBusAddr == 2'd2) & i_DBusByteEn[0];
  assign baudWr = wrAcc & (i_DBusAddr == 2'd3) & (|i_DBusByteEn[1:0]);
  assign txPush = wrAcc & (i_DBusAddr == 2'd0) & i_DBusByteEn[0];

  logic unusedBits;
  assign unusedBits = ^{i_DBusWd[31:16], i_DBusByteEn[3:2]};

  // Control/status registers
  logic [15:0] baudDiv, baudNew;
  logic        irqEn, rxOverrun, txOverflow, rxFrameErr;
  logic        rxValid;
  logic [7:0]  rxByte;

  // TX FIFO
  logic [7:0]       txMem [TX_DEPTH];
  logic [PTR_W-1:0] txWrPtr, txRdPtr;
  logic [CNT_W-1:0] txCount;
  logic             txFull, txEmpty, txPop, txAccept;

  assign txFull   = (txCount == CNT_W'(TX_DEPTH));
  assign txEmpty  = (txCount == '0);
  assign txAccept = txPush & (~txFull | txPop);

  always_ff @(posedge i_Clk) begin
    if (txAccept) txMem[txWrPtr] <= i_DBusWd[7:0];
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txAccept) txWrPtr <= txWrPtr + PTR_W'(1);
      if (txPop)    txRdPtr <= txRdPtr + PTR_W'(1);
      if (txAccept && !txPop)      txCount <= txCount + CNT_W'(1);
      else if (!txAccept && txPop) txCount <= txCount - CNT_W'(1);
    end
  end

  // TX engine state register
  uartState_e txState, txStateN;
  logic [15:0] txCnt, txCntN;
  logic [7:0]  txSh, txShN;
  logic [2:0]  txBit, txBitN;
  logic        txOutN, txTick;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      txState <= IDLE;
      txCnt   <= '0;
      txSh    <= '0;
      txBit   <= '0;
      o_Tx    <= 1'b1;
    end else begin
      txState <= txStateN;
      txCnt   <= txCntN;
      txSh    <= txShN;
      txBit   <= txBitN;
      o_Tx    <= txOutN;
    end
  end

  // TX next state; every bit boundary reloads the counter from the live divisor
  assign txTick = (txCnt == 16'd0);

  always_comb begin
    txStateN = txState;
    txCntN   = txCnt;
    txShN    = txSh;
    txBitN   = txBit;
    txOutN   = o_Tx;
    txPop    = 1'b0;
    case (txState)
      IDLE: begin
        txOutN = 1'b1;
        if (!txEmpty) begin
          txPop    = 1'b1;
          txStateN = START;
          txCntN   = baudDiv - 16'd1;
          txShN    = txMem[txRdPtr];
          txOutN   = 1'b0;
        end
      end
      START: begin
        if (txTick) begin
          txStateN = DATA;
          txCntN   = baudDiv - 16'd1;
          txBitN   = 3'd0;
          txOutN   = txSh[0];
        end else begin
          txCntN = txCnt - 16'd1;
        end
      end
      DATA: begin
        if (txTick) begin
          txCntN = baudDiv - 16'd1;
          if (txBit == 3'd7) begin
            txStateN = STOP;
            txOutN   = 1'b1;
          end else begin
            txBitN = txBit + 3'd1;
            txShN  = {1'b0, txSh[7:1]};
            txOutN = txSh[1];
          end
        end else begin
          txCntN = txCnt - 16'd1;
        end
      end
      STOP: begin
        txOutN = 1'b1;
        if (txTick) begin
          if (!txEmpty) begin
            // Back-to-back byte: straight into START with no idle gap
            txPop    = 1'b1;
            txStateN = START;
            txCntN   = baudDiv - 16'd1;
            txShN    = txMem[txRdPtr];
            txOutN   = 1'b0;
          end else begin
            txStateN = IDLE;
          end
        end else begin
          txCntN = txCnt - 16'd1;
        end
      end
      default: begin
        txStateN = IDLE;
        txOutN   = 1'b1;
      end
    endcase
  end

  // RX synchroniser and falling-edge detect
  logic [1:0] rxSync;
  logic       rxPrev, rxS, rxFall;
  assign rxS    = rxSync[1];
  assign rxFall = rxPrev & ~rxS;

  // RX engine state register
  uartState_e rxState, rxStateN;
  logic [15:0] rxCnt, rxCntN;
  logic [7:0]  rxSh, rxShN;
  logic [2:0]  rxBit, rxBitN;
  logic        rxTick, rxStopOk, rxStopBad;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rxSync  <= 2'b11;
      rxPrev  <= 1'b1;
      rxState <= IDLE;
      rxCnt   <= '0;
      rxSh    <= '0;
      rxBit   <= '0;
    end else begin
      rxSync  <= {rxSync[0], i_Rx};
      rxPrev  <= rxS;
      rxState <= rxStateN;
      rxCnt   <= rxCntN;
      rxSh    <= rxShN;
      rxBit   <= rxBitN;
    end
  end

  // RX next state; first tick lands mid start bit, later ones a bit period apart
  assign rxTick = (rxCnt == 16'd0);

  always_comb begin
    rxStateN  = rxState;
    rxCntN    = rxCnt;
    rxShN     = rxSh;
    rxBitN    = rxBit;
    rxStopOk  = 1'b0;
    rxStopBad = 1'b0;
    case (rxState)
      IDLE: begin
        if (rxFall) begin
          rxStateN = START;
          rxCntN   = (baudDiv >> 1) - 16'd1;
        end
      end
      START: begin
        if (rxTick) begin
          if (rxS) begin
            rxStateN = IDLE;
          end else begin
            rxStateN = DATA;
            rxCntN   = baudDiv - 16'd1;
            rxBitN   = 3'd0;
          end
        end else begin
          rxCntN = rxCnt - 16'd1;
        end
      end
      DATA: begin
        if (rxTick) begin
          rxShN  = {rxS, rxSh[7:1]};
          rxCntN = baudDiv - 16'd1;
          if (rxBit == 3'd7) rxStateN = STOP;
          else               rxBitN   = rxBit + 3'd1;
        end else begin
          rxCntN = rxCnt - 16'd1;
        end
      end
      STOP: begin
        if (rxTick) begin
          rxStateN  = IDLE;
          rxStopOk  = rxS;
          rxStopBad = ~rxS;
        end else begin
          rxCntN = rxCnt - 16'd1;
        end
      end
      default: rxStateN = IDLE;
    endcase
  end

  // Holding register: a read in the load cycle frees the slot for the new byte
  logic rxLoad, rxOvr;
  assign rxLoad = rxStopOk & (~rxValid | rdRx);
  assign rxOvr  = rxStopOk & rxValid & ~rdRx;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rxByte  <= '0;
      rxValid <= 1'b0;
    end else if (rxLoad) begin
      rxByte  <= rxSh;
      rxValid <= 1'b1;
    end else if (rdRx) begin
      rxValid <= 1'b0;
    end
  end

  // Sticky flags (set beats W1C), irq enable, baud divisor with floor of 4
  assign baudNew = {i_DBusByteEn[1] ? i_DBusWd[15:8] : baudDiv[15:8],
                    i_DBusByteEn[0] ? i_DBusWd[7:0]  : baudDiv[7:0]};

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rxOverrun  <= 1'b0;
      txOverflow <= 1'b0;
      rxFrameErr <= 1'b0;
      irqEn      <= 1'b0;
      baudDiv    <= BAUD_RST;
    end else begin
      rxOverrun  <= (rxOverrun  & ~(statWr & i_DBusWd[4])) | rxOvr;
      txOverflow <= (txOverflow & ~(statWr & i_DBusWd[5])) | (txPush & ~txAccept);
      rxFrameErr <= (rxFrameErr & ~(statWr & i_DBusWd[6])) | rxStopBad;
      if (statWr) irqEn <= i_DBusWd[7];
      if (baudWr) baudDiv <= (baudNew < BAUD_MIN) ? BAUD_MIN : baudNew;
    end
  end

  // Read mux and registered outputs
  logic [31:0] statusWord, rdMux;
  assign statusWord = {24'd0, irqEn, rxFrameErr, txOverflow, rxOverrun,
                       rxValid, (txState != IDLE), txEmpty, txFull};

  always_comb begin
    rdMux = '0;
    case (i_DBusAddr)
      2'd1:    rdMux = {23'd0, rxValid, rxByte};
      2'd2:    rdMux = statusWord;
      2'd3:    rdMux = {16'd0, baudDiv};
      default: rdMux = '0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_DBusRd <= '0;
      o_Irq    <= 1'b0;
    end else begin
      o_DBusRd <= rdAcc ? rdMux : 32'd0;
      o_Irq    <= irqEn & (rxValid | txEmpty);
    end
  end

endmodule

// File: tb/tb_dbus_uart.sv
// tb_dbus_uart: self-checking bench for dbus_uart (CLKS_PER_BIT=8, TX_DEPTH=4).
//   Register vectors from a table, directed TX/RX/reset sequences, and
//   randomized frames checked against an ideal serial-waveform and
//   holding-register model.
module tb_dbus_uart;

  localparam int PER   = 8;
  localparam int DEPTH = 4;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Sel = 1'b0;
  logic [1:0]  i_DBusAddr = '0;
  logic        i_DBusRe = 1'b0;
  logic        i_DBusWe = 1'b0;
  logic [3:0]  i_DBusByteEn = '0;
  logic [31:0] i_DBusWd = '0;
  logic [31:0] o_DBusRd;
  logic        i_Rx = 1'b1;
  logic        o_Tx;
  logic        o_Irq;

  dbus_uart #(.TX_DEPTH(DEPTH), .CLKS_PER_BIT(PER)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Sel(i_Sel), .i_DBusAddr(i_DBusAddr),
    .i_DBusRe(i_DBusRe), .i_DBusWe(i_DBusWe), .i_DBusByteEn(i_DBusByteEn),
    .i_DBusWd(i_DBusWd), .o_DBusRd(o_DBusRd), .i_Rx(i_Rx), .o_Tx(o_Tx),
    .o_Irq(o_Irq)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    i_Sel = 1'b1; i_DBusWe = 1'b1; i_DBusAddr = a; i_DBusWd = d; i_DBusByteEn = be;
    tick(1);
    i_Sel = 1'b0; i_DBusWe = 1'b0; i_DBusByteEn = '0; i_DBusWd = '0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    i_Sel = 1'b1; i_DBusRe = 1'b1; i_DBusAddr = a;
    tick(1);
    i_Sel = 1'b0; i_DBusRe = 1'b0;
    d = o_DBusRd;
  endtask

  // Serial line recorder (sampled on the falling edge) and ideal waveform
  logic txQ[$];
  logic expTx[$];
  bit   recOn = 1'b0;

  always @(negedge i_Clk) if (recOn) txQ.push_back(o_Tx);

  function automatic void addFrame(input logic [7:0] b, input int per);
    for (int i = 0; i < per; i++) expTx.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < per; i++) expTx.push_back(b[k]);
    for (int i = 0; i < per; i++) expTx.push_back(1'b1);
  endfunction

  task automatic startRec();
    txQ.delete();
    expTx.delete();
    recOn = 1'b1;
  endtask

  // First low sample must be 2 (write cycle, pop cycle), then the exact frames, then idle
  task automatic checkTx(input string name);
    int first = -1;
    int mism = 0;
    recOn = 1'b0;
    foreach (txQ[i]) if (first < 0 && txQ[i] === 1'b0) first = i;
    check({name, "_lat"}, 32'(first), 32'd2);
    if (first < 0) first = 0;
    for (int j = 0; j < expTx.size(); j++)
      if (first + j >= txQ.size() || txQ[first + j] !== expTx[j]) mism++;
    if (first + expTx.size() >= txQ.size() || txQ[first + expTx.size()] !== 1'b1) mism++;
    check({name, "_wave"}, 32'(mism), 32'd0);
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit, input int per);
    i_Rx = 1'b0; tick(per);
    for (int k = 0; k < 8; k++) begin
      i_Rx = b[k]; tick(per);
    end
    i_Rx = stopBit; tick(per);
    i_Rx = 1'b1; tick(per);
  endtask

  typedef struct {
    logic        sel;
    logic        re;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic sel, input logic re, input logic we,
                              input logic [1:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.sel = sel; v.re = re; v.we = we; v.addr = addr; v.be = be; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        stopOk;
    logic        mValid, mOvr, mFe;
    logic [7:0]  mByte;
    int          per, nb, n;

    // Register access table: exp is o_DBusRd the cycle after the vector
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h8));
    vecs.push_back(mk(1, 1, 0, 2'd2, 4'h0, 32'h0,    32'h2));
    vecs.push_back(mk(0, 1, 0, 2'd3, 4'h0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd0, 4'h0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd1, 4'h0, 32'h0,    32'h0));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'h3, 32'h1234, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h1234));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'h1, 32'hFF56, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h1256));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'h2, 32'hAB00, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'hAB56));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'h3, 32'h0003, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h4));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'hF, 32'h0,    32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h4));
    vecs.push_back(mk(1, 1, 1, 2'd3, 4'h3, 32'h0009, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h9));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'h0, 32'h0020, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h9));
    vecs.push_back(mk(1, 0, 1, 2'd2, 4'h2, 32'h0080, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd2, 4'h0, 32'h0,    32'h2));
    vecs.push_back(mk(1, 0, 1, 2'd3, 4'h3, 32'h0008, 32'h0));
    vecs.push_back(mk(1, 1, 0, 2'd3, 4'h0, 32'h0,    32'h8));

    // Reset state
    tick(3);
    check("rst_tx", 32'(o_Tx), 32'd1);
    check("rst_rd", o_DBusRd, 32'd0);
    check("rst_irq", 32'(o_Irq), 32'd0);
    i_Rst_n = 1'b1;
    tick(2);

    foreach (vecs[i]) begin
      i_Sel = vecs[i].sel; i_DBusRe = vecs[i].re; i_DBusWe = vecs[i].we;
      i_DBusAddr = vecs[i].addr; i_DBusByteEn = vecs[i].be; i_DBusWd = vecs[i].wd;
      tick(1);
      i_Sel = 1'b0; i_DBusRe = 1'b0; i_DBusWe = 1'b0; i_DBusByteEn = '0; i_DBusWd = '0;
      check($sformatf("vec%0d", i), o_DBusRd, vecs[i].exp);
    end

    // Single byte 0x55
    startRec();
    addFrame(8'h55, PER);
    busWrite(2'd0, 32'h55, 4'hF);
    tick(20);
    busRead(2'd2, d);
    check("t1_busy", d, 32'h06);
    tick(80);
    checkTx("t1");
    busRead(2'd2, d);
    check("t1_done", d, 32'h02);

    // Six back-to-back writes: five sent without gaps, sixth dropped
    startRec();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) addFrame(8'(i), PER);
      busWrite(2'd0, 32'(i), 4'hF);
    end
    busRead(2'd2, d);
    check("t2_full", d, 32'h25);
    tick(5 * 10 * PER + 20);
    checkTx("t2");
    busRead(2'd2, d);
    check("t2_ovf", d, 32'h22);
    busWrite(2'd2, 32'h20, 4'hF);
    busRead(2'd2, d);
    check("t2_clr", d, 32'h02);

    // RX single frame
    sendRx(8'hA3, 1'b1, PER);
    busRead(2'd1, d);
    check("t3_rx1", d, 32'h1A3);
    busRead(2'd1, d);
    check("t3_rx2", d, 32'h0A3);

    // Overrun, then framing error
    sendRx(8'h11, 1'b1, PER);
    sendRx(8'h22, 1'b1, PER);
    busRead(2'd2, d);
    check("t4_ovr", d, 32'h1A);
    busRead(2'd1, d);
    check("t4_rx", d, 32'h111);
    sendRx(8'h33, 1'b0, PER);
    busRead(2'd2, d);
    check("t4_fe", d, 32'h52);
    busRead(2'd1, d);
    check("t4_rxkeep", d, 32'h011);
    busWrite(2'd2, 32'h70, 4'hF);
    busRead(2'd2, d);
    check("t4_clr", d, 32'h02);

    // One-clock low glitch is rejected at the mid-start check
    i_Rx = 1'b0; tick(1); i_Rx = 1'b1; tick(3 * PER);
    busRead(2'd2, d);
    check("glitch", d, 32'h02);

    // Baud clamp and 4-clock bit period
    busWrite(2'd3, 32'h2, 4'hF);
    busRead(2'd3, d);
    check("t5_baud", d, 32'h4);
    startRec();
    addFrame(8'hC4, 4);
    busWrite(2'd0, 32'hC4, 4'hF);
    tick(10 * 4 + 12);
    checkTx("t5");

    // Interrupt enable with both paths empty
    busWrite(2'd2, 32'h80, 4'hF);
    n = 0;
    while (!o_Irq && n < 2) begin
      tick(1);
      n++;
    end
    check("t5_irq", 32'(o_Irq), 32'd1);
    busWrite(2'd2, 32'h00, 4'hF);
    tick(2);
    check("t5_irqoff", 32'(o_Irq), 32'd0);

    // Randomized frames against the model
    mValid = 1'b0; mOvr = 1'b0; mFe = 1'b0; mByte = 8'h11;
    for (int r = 0; r < 3; r++) begin
      per = $urandom_range(4, 10);
      busWrite(2'd3, 32'(per), 4'h3);
      nb = $urandom_range(1, DEPTH);
      startRec();
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        addFrame(b, per);
        busWrite(2'd0, {24'd0, b}, 4'h1);
      end
      tick(nb * 10 * per + 20);
      checkTx($sformatf("rnd%0d_tx", r));
      for (int k = 0; k < 5; k++) begin
        b = 8'($urandom);
        stopOk = ($urandom_range(0, 3) != 0);
        sendRx(b, stopOk, per);
        if (!stopOk) mFe = 1'b1;
        else if (!mValid) begin mValid = 1'b1; mByte = b; end
        else mOvr = 1'b1;
        busRead(2'd2, d);
        check($sformatf("rnd%0d_%0d_st", r, k), d,
              {24'd0, 1'b0, mFe, 1'b0, mOvr, mValid, 1'b0, 1'b1, 1'b0});
        if ($urandom_range(0, 1) == 1) begin
          busRead(2'd1, d);
          check($sformatf("rnd%0d_%0d_rx", r, k), d, {23'd0, mValid, mByte});
          mValid = 1'b0;
        end
        if ($urandom_range(0, 2) == 0) begin
          busWrite(2'd2, 32'h70, 4'hF);
          mOvr = 1'b0; mFe = 1'b0;
        end
      end
    end

    // Reset in the middle of a data bit
    busWrite(2'd3, 32'h8, 4'hF);
    busWrite(2'd0, 32'h00, 4'hF);
    tick(30);
    check("t6_data", 32'(o_Tx), 32'd0);
    #3;
    i_Rst_n = 1'b0;
    #1;
    check("t6_rst_tx", 32'(o_Tx), 32'd1);
    tick(2);
    i_Rst_n = 1'b1;
    tick(2);
    busRead(2'd2, d);
    check("t6_status", d, 32'h02);
    busRead(2'd3, d);
    check("t6_baud", d, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
